// File: rtl/wb_capture_buffer.sv
// Triggered ADC capture buffer with a Wishbone register/read port.
// A 128-bit stream is written into block RAM after a trigger. The captured
// beats are read back as 32-bit words over Wishbone.
//
// Wishbone handshake: an access is taken in any cycle where cyc&stb=1,
// wb_ack_o=0 and no earlier access is still in flight. wb_ack_o rises exactly
// two cycles after the access is taken and stays high for one cycle, with
// wb_dat_o valid in that cycle. The AXI-stream side has no backpressure:
// tready stays 1 outside reset, and beats that arrive outside CAPTURE are dropped.
module wb_capture_buffer #(
  parameter int DEPTH_LOG2 = 8
) (
  input  logic         wb_clk_i,
  input  logic         wb_rst_i,
  input  logic         wb_cyc_i,
  input  logic         wb_stb_i,
  input  logic         wb_we_i,
  input  logic [21:0]  wb_adr_i,
  input  logic [31:0]  wb_dat_i,
  input  logic [3:0]   wb_sel_i,
  output logic [31:0]  wb_dat_o,
  output logic         wb_ack_o,
  output logic         wb_err_o,
  output logic         wb_rty_o,
  input  logic [127:0] s_axis_tdata,
  input  logic         s_axis_tvalid,
  output logic         s_axis_tready,
  input  logic         trig_i,
  output logic         done_o,
  output logic [1:0]   fsm_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam int DEPTH = 1 << DEPTH_LOG2;

  state_t                state, state_next;
  logic [DEPTH_LOG2:0]   count, count_next;
  logic [DEPTH_LOG2-1:0] length;
  logic                  mem_we;

  logic [127:0]          mem [DEPTH];
  logic [127:0]          rd_q;

  // Access decode for the cycle in which an access is taken
  logic                  acc;
  logic                  is_reg;
  logic [10:0]           reg_off;
  logic                  wr_ctrl, wr_len, rd_buf;
  logic                  arm, abort, swtrig;

  // Access in flight, one cycle after it was taken
  logic                  p1_valid;
  logic                  p1_we;
  logic                  p1_is_reg;
  logic [10:0]           p1_off;
  logic [1:0]            p1_lane;
  logic [31:0]           rd_data;

  logic                  unused_bits;

  assign unused_bits = ^{wb_sel_i, wb_adr_i[21:14], wb_adr_i[1:0], wb_dat_i};

  assign acc     = wb_cyc_i & wb_stb_i & ~wb_ack_o & ~p1_valid;
  assign is_reg  = ~wb_adr_i[13];
  assign reg_off = wb_adr_i[12:2];
  assign wr_ctrl = acc & wb_we_i & is_reg & (reg_off == 11'd0);
  assign wr_len  = acc & wb_we_i & is_reg & (reg_off == 11'd2)
                   & ((state == IDLE) | (state == DONE));
  assign rd_buf  = acc & ~wb_we_i & ~is_reg;
  assign arm     = wr_ctrl & wb_dat_i[0];
  assign abort   = wr_ctrl & wb_dat_i[1];
  assign swtrig  = wr_ctrl & wb_dat_i[2];

  assign wb_err_o  = 1'b0;
  assign wb_rty_o  = 1'b0;
  assign done_o    = (state == DONE);
  assign fsm_state = state;

  // Capture FSM next state and beat counter; ABORT beats every other request
  always_comb begin
    state_next = state;
    count_next = count;
    mem_we     = 1'b0;
    if (abort) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (arm) begin
            state_next = ARMED;
            count_next = '0;
          end
        end
        ARMED: begin
          if (trig_i || swtrig) state_next = CAPTURE;
        end
        CAPTURE: begin
          if (s_axis_tvalid) begin
            mem_we     = ~wb_rst_i;
            count_next = count + 1'b1;
            if (count == {1'b0, length}) state_next = DONE;
          end
        end
        DONE: begin
          if (arm) begin
            state_next = ARMED;
            count_next = '0;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Capture FSM state register
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
    end
  end

  // LENGTH register; only writable while no capture is armed or running
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      length <= '1;
    end else if (wr_len) begin
      length <= wb_dat_i[DEPTH_LOG2-1:0];
    end
  end

  // Capture memory: stream write port plus one-cycle-latency read port, never cleared
  always_ff @(posedge wb_clk_i) begin
    if (mem_we) mem[count[DEPTH_LOG2-1:0]] <= s_axis_tdata;
    if (rd_buf) rd_q <= mem[wb_adr_i[DEPTH_LOG2+3:4]];
  end

  // Read data mux, evaluated one cycle after the access was taken
  always_comb begin
    rd_data = '0;
    if (p1_is_reg) begin
      case (p1_off)
        11'd1:   rd_data = {16'(count), 14'd0, state};
        11'd2:   rd_data = 32'(length);
        default: rd_data = '0;
      endcase
    end else begin
      rd_data = rd_q[32*p1_lane +: 32];
    end
  end

  // Two-stage access pipeline that produces the single-cycle acknowledge
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      p1_valid      <= 1'b0;
      p1_we         <= 1'b0;
      p1_is_reg     <= 1'b0;
      p1_off        <= '0;
      p1_lane       <= '0;
      wb_ack_o      <= 1'b0;
      wb_dat_o      <= '0;
      s_axis_tready <= 1'b0;
    end else begin
      s_axis_tready <= 1'b1;
      p1_valid      <= acc;
      if (acc) begin
        p1_we     <= wb_we_i;
        p1_is_reg <= is_reg;
        p1_off    <= reg_off;
        p1_lane   <= wb_adr_i[3:2];
      end
      wb_ack_o <= p1_valid;
      wb_dat_o <= (p1_valid && !p1_we) ? rd_data : 32'd0;
    end
  end

endmodule

// File: tb/tb_wb_capture_buffer.sv
// Bench for wb_capture_buffer: register map, capture flows, ack timing, reset.
module tb_wb_capture_buffer;

  localparam logic [21:0] A_CTRL   = 22'h0000;
  localparam logic [21:0] A_STATUS = 22'h0004;
  localparam logic [21:0] A_LEN    = 22'h0008;
  localparam logic [21:0] A_BUF    = 22'h2000;

  logic         clk;
  logic         rst;
  logic         cyc, stb, we;
  logic [21:0]  adr;
  logic [31:0]  dat_i;
  logic [3:0]   sel;
  logic [31:0]  dat_o;
  logic         ack, err, rty;
  logic [127:0] tdata;
  logic         tvalid, tready;
  logic         trig, done;
  logic [1:0]   fsm_state;

  int checks = 0;
  int errors = 0;
  logic [31:0]  exp_q[$];
  logic [127:0] beat_q[$];

  wb_capture_buffer #(.DEPTH_LOG2(8)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb_cyc_i(cyc), .wb_stb_i(stb),
    .wb_we_i(we), .wb_adr_i(adr), .wb_dat_i(dat_i), .wb_sel_i(sel),
    .wb_dat_o(dat_o), .wb_ack_o(ack), .wb_err_o(err), .wb_rty_o(rty),
    .s_axis_tdata(tdata), .s_axis_tvalid(tvalid), .s_axis_tready(tready),
    .trig_i(trig), .done_o(done), .fsm_state(fsm_state)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  // Driver: one Wishbone read, returns data and ack latency in cycles
  task automatic wb_read(input logic [21:0] a, output logic [31:0] d, output int lat);
    logic got;
    got = 1'b0;
    d   = '0;
    lat = 0;
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = a;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      lat++;
      if (ack === 1'b1) begin
        d   = dat_o;
        got = 1'b1;
        break;
      end
    end
    cyc = 1'b0; stb = 1'b0;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL rd_timeout adr=%h: ack=%b required 1 within 8 cycles", a, ack);
    end
  endtask

  // Driver: one Wishbone write
  task automatic wb_write(input logic [21:0] a, input logic [31:0] d);
    logic got;
    got = 1'b0;
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = a; dat_i = d;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ack === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL wr_timeout adr=%h: ack=%b required 1 within 8 cycles", a, ack);
    end
  endtask

  task automatic test_reset;
    logic [31:0] d, e;
    int lat;
    checks++;
    if ({ack, dat_o, tready, done, err, rty, fsm_state} !== 38'd0) begin
      errors++;
      $display("FAIL reset_outputs: ack=%b dat=%h tready=%b done=%b err=%b rty=%b state=%0d required all 0",
               ack, dat_o, tready, done, err, rty, fsm_state);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (tready !== 1'b1) begin
      errors++;
      $display("FAIL tready_after_reset: got %b required 1", tready);
    end
    exp_q.push_back(32'h0);        wb_read(A_STATUS, d, lat); e = exp_q.pop_front();
    checks++; if (d !== e) begin errors++; $display("FAIL reset_status: got %h required %h", d, e); end
    exp_q.push_back(32'h0000_00FF); wb_read(A_LEN, d, lat); e = exp_q.pop_front();
    checks++; if (d !== e) begin errors++; $display("FAIL reset_length: got %h required %h", d, e); end
  endtask

  // LENGTH=3, ARM, SWTRIG, continuous stream of beat k = {8{k}}
  task automatic test_swtrig_capture;
    logic [31:0] d, e;
    logic [15:0] kv;
    int lat;
    wb_write(A_LEN, 32'd3);
    wb_write(A_CTRL, 32'h1);
    wb_write(A_CTRL, 32'h4);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      kv = k[15:0];
      tvalid = 1'b1;
      tdata  = {8{kv}};
    end
    @(negedge clk);
    tvalid = 1'b0;
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL swtrig_done: got %b required 1", done); end
    exp_q.push_back(32'h0004_0003); wb_read(A_STATUS, d, lat); e = exp_q.pop_front();
    checks++; if (d !== e) begin errors++; $display("FAIL swtrig_status: got %h required %h", d, e); end
    for (int w = 0; w < 16; w++) begin
      kv = 16'(w >> 2);
      exp_q.push_back({kv, kv});
      wb_read(A_BUF + 22'(w * 4), d, lat);
      e = exp_q.pop_front();
      checks++;
      if (d !== e) begin errors++; $display("FAIL swtrig_word%0d: got %h required %h", w, d, e); end
    end
  endtask

  // LENGTH=5, trig_i pulse, tvalid toggling; trigger-cycle beat must be dropped
  task automatic test_trig_toggle;
    logic [31:0] d, e;
    int lat;
    int stored;
    stored = 0;
    beat_q.delete();
    wb_write(A_LEN, 32'd5);
    wb_write(A_CTRL, 32'h1);
    checks++;
    if (fsm_state !== 2'd1) begin errors++; $display("FAIL rearm_state: got %0d required 1", fsm_state); end
    @(negedge clk);
    trig   = 1'b1;
    tvalid = 1'b1;
    tdata  = {4{32'hDEAD_BEEF}};
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      trig = 1'b0;
      checks++;
      if (done !== (stored >= 6)) begin
        errors++;
        $display("FAIL toggle_done step%0d: got %b required %b", i, done, (stored >= 6));
      end
      tvalid = ((i % 2) == 0);
      tdata  = {$urandom, $urandom, $urandom, $urandom};
      if (tvalid && stored < 6) begin
        beat_q.push_back(tdata);
        stored++;
      end
    end
    @(negedge clk);
    tvalid = 1'b0;
    exp_q.push_back(32'h0006_0003); wb_read(A_STATUS, d, lat); e = exp_q.pop_front();
    checks++; if (d !== e) begin errors++; $display("FAIL toggle_status: got %h required %h", d, e); end
    for (int w = 0; w < 24; w++) begin
      exp_q.push_back(beat_q[w / 4][32 * (w % 4) +: 32]);
      wb_read(A_BUF + 22'(w * 4), d, lat);
      e = exp_q.pop_front();
      checks++;
      if (d !== e) begin errors++; $display("FAIL toggle_word%0d: got %h required %h", w, d, e); end
    end
  endtask

  // Ack latency of 2 and one ack per 3 cycles with stb held
  task automatic test_back_to_back;
    logic [31:0] d, e;
    logic [8:0]  pat, exp_pat;
    int lat;
    wb_read(A_STATUS, d, lat);
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL ack_latency: got %0d required 2", lat); end
    pat = '0;
    exp_pat = '0;
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = A_STATUS;
    for (int i = 0; i < 3; i++) exp_q.push_back(32'h0006_0003);
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      exp_pat[i-1] = ((i % 3) == 2);
      pat[i-1] = ack;
      if (ack === 1'b1 && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (dat_o !== e) begin errors++; $display("FAIL b2b_data cycle%0d: got %h required %h", i, dat_o, e); end
      end
    end
    cyc = 1'b0; stb = 1'b0;
    exp_q.delete();
    repeat (3) @(negedge clk);
    checks++;
    if (pat !== exp_pat) begin errors++; $display("FAIL b2b_ack_pattern: got %b required %b", pat, exp_pat); end
  endtask

  // ABORT after 5 beats; later triggers ignored
  task automatic test_abort;
    logic [31:0] d, e;
    int lat;
    wb_write(A_LEN, 32'd15);
    wb_write(A_CTRL, 32'h1);
    wb_write(A_CTRL, 32'h4);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      tvalid = 1'b1;
      tdata  = {$urandom, $urandom, $urandom, $urandom};
    end
    @(negedge clk);
    tvalid = 1'b0;
    wb_write(A_CTRL, 32'h2);
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL abort_done: got %b required 0", done); end
    exp_q.push_back(32'h0005_0000); wb_read(A_STATUS, d, lat); e = exp_q.pop_front();
    checks++; if (d !== e) begin errors++; $display("FAIL abort_status: got %h required %h", d, e); end
    @(negedge clk);
    trig = 1'b1; tvalid = 1'b1;
    repeat (3) @(negedge clk);
    trig = 1'b0; tvalid = 1'b0;
    exp_q.push_back(32'h0005_0000); wb_read(A_STATUS, d, lat); e = exp_q.pop_front();
    checks++; if (d !== e) begin errors++; $display("FAIL abort_trig_ignored: got %h required %h", d, e); end
  endtask

  // LENGTH guard, ARM+ABORT priority, unmapped/CTRL reads, LENGTH width
  task automatic test_length_guard;
    logic [31:0] d, e;
    int lat;
    wb_write(A_CTRL, 32'h1);
    wb_write(A_LEN, 32'd7);
    exp_q.push_back(32'd15); wb_read(A_LEN, d, lat); e = exp_q.pop_front();
    checks++; if (d !== e) begin errors++; $display("FAIL len_guard: got %h required %h", d, e); end
    exp_q.push_back(32'h0000_0001); wb_read(A_STATUS, d, lat); e = exp_q.pop_front();
    checks++; if (d !== e) begin errors++; $display("FAIL armed_status: got %h required %h", d, e); end
    wb_write(A_CTRL, 32'h2);
    wb_write(A_CTRL, 32'h3);
    checks++;
    if (fsm_state !== 2'd0) begin errors++; $display("FAIL arm_abort_state: got %0d required 0", fsm_state); end
    wb_write(A_LEN, 32'hFFFF_FFF5);
    exp_q.push_back(32'h0000_00F5); wb_read(A_LEN, d, lat); e = exp_q.pop_front();
    checks++; if (d !== e) begin errors++; $display("FAIL len_width: got %h required %h", d, e); end
    wb_write(22'h0010, 32'hFFFF_FFFF);
    exp_q.push_back(32'h0); wb_read(22'h0010, d, lat); e = exp_q.pop_front();
    checks++; if (d !== e) begin errors++; $display("FAIL unmapped_read: got %h required %h", d, e); end
    exp_q.push_back(32'h0); wb_read(A_CTRL, d, lat); e = exp_q.pop_front();
    checks++; if (d !== e) begin errors++; $display("FAIL ctrl_read: got %h required %h", d, e); end
    wb_write(A_LEN, 32'd9);
  endtask

  // Reset during capture with a read in flight
  task automatic test_reset_mid;
    logic [31:0] d, e;
    logic        ack_seen;
    int lat;
    beat_q.delete();
    wb_write(A_CTRL, 32'h1);
    wb_write(A_CTRL, 32'h4);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      tvalid = 1'b1;
      tdata  = {$urandom, $urandom, $urandom, $urandom};
      beat_q.push_back(tdata);
    end
    @(negedge clk);
    tvalid = 1'b0;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = A_STATUS;
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0;
    rst = 1'b1;
    ack_seen = 1'b0;
    @(negedge clk);
    ack_seen = ack_seen | ack;
    checks++;
    if ({tready, done, fsm_state} !== 4'd0) begin
      errors++;
      $display("FAIL midreset_outputs: tready=%b done=%b state=%0d required 0", tready, done, fsm_state);
    end
    @(negedge clk);
    ack_seen = ack_seen | ack;
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      ack_seen = ack_seen | ack;
    end
    checks++;
    if (ack_seen !== 1'b0) begin errors++; $display("FAIL midreset_ack: got %b required 0", ack_seen); end
    exp_q.push_back(32'h0); wb_read(A_STATUS, d, lat); e = exp_q.pop_front();
    checks++; if (d !== e) begin errors++; $display("FAIL midreset_status: got %h required %h", d, e); end
    exp_q.push_back(32'h0000_00FF); wb_read(A_LEN, d, lat); e = exp_q.pop_front();
    checks++; if (d !== e) begin errors++; $display("FAIL midreset_length: got %h required %h", d, e); end
    exp_q.push_back(beat_q[0][31:0]); wb_read(A_BUF, d, lat); e = exp_q.pop_front();
    checks++; if (d !== e) begin errors++; $display("FAIL midreset_keep0: got %h required %h", d, e); end
    exp_q.push_back(beat_q[2][127:96]); wb_read(A_BUF + 22'h2C, d, lat); e = exp_q.pop_front();
    checks++; if (d !== e) begin errors++; $display("FAIL midreset_keep11: got %h required %h", d, e); end
  endtask

  // Sequencer and final report
  initial begin
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; dat_i = '0;
    sel = 4'hF; tdata = '0; tvalid = 1'b0; trig = 1'b0;
    repeat (3) @(negedge clk);
    test_reset;
    test_swtrig_capture;
    test_trig_toggle;
    test_back_to_back;
    test_abort;
    test_length_guard;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
